// File: rtl/imm_encode_pkg.sv
// Shared immediate-type and error-code definitions for the immediate encoder
// and the decode-side immediate extractor.
//   IMM_*      : immediate format selectors (3-bit)
//   ERR_*      : encoder result codes (2-bit)
//   check_imm  : range/alignment/type check for an encode request
//   extract_imm: decode-side reconstruction of the sign-extended immediate
package imm_encode_pkg;

  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_TYPE  = 2'b11;

  // True when v[63:lsb] are all equal, i.e. v fits a signed (lsb+1)-bit field.
  function automatic logic upper_same(input logic [63:0] v, input int unsigned lsb);
    logic [63:0] s;
    s = $signed(v) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

  // Priority: bad type > misaligned > out of range.
  function automatic logic [1:0] check_imm(input logic [2:0] t, input logic [63:0] imm);
    logic in_rng;
    in_rng = 1'b0;
    case (t)
      IMM_I, IMM_S: in_rng = upper_same(imm, 11);
      IMM_B:        in_rng = upper_same(imm, 12);
      IMM_J:        in_rng = upper_same(imm, 20);
      IMM_U:        in_rng = (imm[11:0] == '0) && upper_same(imm, 31);
      default:      return ERR_TYPE;
    endcase
    if (((t == IMM_B) || (t == IMM_J)) && imm[0]) return ERR_ALIGN;
    return in_rng ? ERR_OK : ERR_RANGE;
  endfunction

  function automatic logic [63:0] extract_imm(input logic [2:0] t, input logic [31:0] inst);
    case (t)
      IMM_I:   return {{52{inst[31]}}, inst[31:20]};
      IMM_S:   return {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:   return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/imm_encode_scatter.sv
// imm_scatter: combinational placement of an immediate into the RISC-V
// I/S/B/U/J bit positions of a base instruction word.
//   type_i : immediate format (IMM_*); unknown formats return base_i as-is
//   imm_i  : low 32 bits of the immediate (higher bits never reach the word)
//   base_i : instruction with opcode/rd/rs/funct fields
//   inst_o : base_i with the immediate fields replaced
module imm_scatter
  import imm_encode_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] inst_o
);

  always_comb begin
    inst_o = base_i;
    case (type_i)
      IMM_I: inst_o[31:20] = imm_i[11:0];
      IMM_S: begin
        inst_o[31:25] = imm_i[11:5];
        inst_o[11:7]  = imm_i[4:0];
      end
      IMM_B: begin
        inst_o[31]    = imm_i[12];
        inst_o[30:25] = imm_i[10:5];
        inst_o[11:8]  = imm_i[4:1];
        inst_o[7]     = imm_i[11];
      end
      IMM_U: inst_o[31:12] = imm_i[31:12];
      IMM_J: begin
        inst_o[31]    = imm_i[20];
        inst_o[30:21] = imm_i[10:1];
        inst_o[20]    = imm_i[11];
        inst_o[19:12] = imm_i[19:12];
      end
      default: inst_o = base_i;
    endcase
  end

endmodule

// File: rtl/imm_encode.sv
// imm_encode: two-stage valid/ready immediate encoder (inverse of the core's
// immediate extractor). Stage 1 registers the request and its check result,
// stage 2 registers the scattered instruction word.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake
//   in_imm_type/imm/base  : format, 64-bit signed immediate, base instruction
//   out_valid/out_ready   : result handshake
//   out_inst/out_err      : encoded instruction and ERR_* code
//   err_cnt               : saturating count of accepted results with an error
//   rt_fail               : sticky round-trip mismatch flag
// Optional feature macro: IMMENC_ROUNDTRIP_CHECK_EN (re-extracts each accepted
// error-free result and compares it with the original immediate; when
// undefined rt_fail is tied low).
module imm_encode
  import imm_encode_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_type,
  input  logic [63:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             rt_fail
);

`ifdef IMMENC_ROUNDTRIP_CHECK_EN
  localparam int unsigned KEEP_W = 64;
`else
  localparam int unsigned KEEP_W = 32;
`endif

  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_type_q,  s1_type_d;
  logic [KEEP_W-1:0] s1_imm_q,   s1_imm_d;
  logic [31:0]       s1_base_q,  s1_base_d;
  logic [1:0]        s1_err_q,   s1_err_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic [1:0]        out_err_q,   out_err_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
  logic              s1_adv, s2_adv, s2_load;
  logic [31:0]       scat_inst;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign s2_load  = s2_adv && s1_valid_q;
  assign in_ready = s1_adv;

  imm_scatter u_scatter (
    .type_i (s1_type_q),
    .imm_i  (s1_imm_q[31:0]),
    .base_i (s1_base_q),
    .inst_o (scat_inst)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_type_d   = s1_type_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_type_d = in_imm_type;
        s1_imm_d  = in_imm[KEEP_W-1:0];
        s1_base_d = in_base;
        s1_err_d  = check_imm(in_imm_type, in_imm);
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = scat_inst;
        out_err_d  = s1_err_q;
      end
    end
    if (out_valid_q && out_ready && (out_err_q != ERR_OK) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_type_q   <= '0;
      s1_imm_q    <= '0;
      s1_base_q   <= '0;
      s1_err_q    <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_type_q   <= s1_type_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

`ifdef IMMENC_ROUNDTRIP_CHECK_EN
  // Original request travels alongside the stage-2 result for the comparison.
  logic [2:0]  s2_type_q;
  logic [63:0] s2_imm_q;
  logic        rt_fail_q, rt_fail_d;
  logic        rt_hit;

  always_comb begin
    rt_hit    = out_valid_q && out_ready && (out_err_q == ERR_OK) &&
                (extract_imm(s2_type_q, out_inst_q) != s2_imm_q);
    rt_fail_d = rt_fail_q || rt_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_type_q <= '0;
      s2_imm_q  <= '0;
      rt_fail_q <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_type_q <= s1_type_q;
        s2_imm_q  <= s1_imm_q;
      end
      rt_fail_q <= rt_fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rt_hit)
      $error("imm_encode round-trip mismatch: inst %h imm %h", out_inst_q, s2_imm_q);
  end

  assign rt_fail = rt_fail_q;
`else
  assign rt_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_imm_type;
  logic [63:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [15:0] err_cnt;
  logic        rt_fail;

  imm_encode #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm_type (in_imm_type),
    .in_imm      (in_imm),
    .in_base     (in_base),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_err     (out_err),
    .err_cnt     (err_cnt),
    .rt_fail     (rt_fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  err;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned exp_err_cnt = 0;
  logic        bp_rand = 1'b0;

  logic [63:0] bnd[14];
  initial begin
    bnd[0]  = 64'd2047;          bnd[1]  = -64'sd2048;
    bnd[2]  = 64'd2048;          bnd[3]  = -64'sd2049;
    bnd[4]  = 64'd4094;          bnd[5]  = -64'sd4096;
    bnd[6]  = 64'd4096;          bnd[7]  = 64'h000F_FFFE;
    bnd[8]  = -64'sd1048576;     bnd[9]  = 64'h0010_0000;
    bnd[10] = 64'h7FFF_F000;     bnd[11] = 64'hFFFF_FFFF_8000_0000;
    bnd[12] = 64'h8000_0000;     bnd[13] = 64'd0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: field placement expressed with masks and shifts.
  function automatic logic [31:0] exp_inst(input logic [2:0] t, input logic [63:0] imm,
                                           input logic [31:0] base);
    logic [31:0] lo;
    lo = imm[31:0];
    case (t)
      3'd1: return (base & 32'h000F_FFFF) | ((lo & 32'hFFF) << 20);
      3'd2: return (base & 32'h01FF_F07F) | (((lo >> 5) & 32'h7F) << 25) | ((lo & 32'h1F) << 7);
      3'd3: return (base & 32'h01FF_F07F) | (((lo >> 12) & 32'h1) << 31) |
                   (((lo >> 5) & 32'h3F) << 25) | (((lo >> 1) & 32'hF) << 8) |
                   (((lo >> 11) & 32'h1) << 7);
      3'd4: return (base & 32'h0000_0FFF) | (lo & 32'hFFFF_F000);
      3'd5: return (base & 32'h0000_0FFF) | (((lo >> 20) & 32'h1) << 31) |
                   (((lo >> 1) & 32'h3FF) << 21) | (((lo >> 11) & 32'h1) << 20) |
                   (((lo >> 12) & 32'hFF) << 12);
      default: return base;
    endcase
  endfunction

  // Reference model: range as a signed-interval test on the integer value.
  function automatic logic [1:0] exp_err(input logic [2:0] t, input logic [63:0] imm);
    longint s;
    longint lim;
    s = $signed(imm);
    if (t == 3'd0 || t > 3'd5) return 2'b11;
    if ((t == 3'd3 || t == 3'd5) && imm[0]) return 2'b10;
    case (t)
      3'd1, 3'd2: lim = 2048;
      3'd3:       lim = 4096;
      3'd5:       lim = 1048576;
      default:    lim = 64'sh8000_0000;
    endcase
    if (t == 3'd4 && (s % 4096) != 0) return 2'b01;
    return (s < -lim || s >= lim) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [63:0] rand_imm(input logic [2:0] t);
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = bnd[$urandom_range(0, 13)];
      1: r = $signed(r) >>> $urandom_range(40, 60);
      2: r = ($signed(r) >>> 32) & ~64'hFFF;
      default: ;
    endcase
    if ((t == 3'd3 || t == 3'd5) && $urandom_range(0, 3) != 0) r[0] = 1'b0;
    return r;
  endfunction

  task automatic send(input logic [2:0] t, input logic [63:0] imm, input logic [31:0] base);
    int unsigned waited;
    waited = 0;
    in_valid = 1'b1;
    in_imm_type = t;
    in_imm = imm;
    in_base = base;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", waited);
    end else begin
      sbq.push_back('{inst: exp_inst(t, imm, base), err: exp_err(t, imm)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got inst %h err %0d, required no output", out_inst, out_err);
      end else begin
        e_mon = sbq.pop_front();
        check("out_inst", {32'b0, out_inst}, {32'b0, e_mon.inst});
        check("out_err", {62'b0, out_err}, {62'b0, e_mon.err});
        if (e_mon.err != 2'b00) exp_err_cnt++;
      end
    end
  end

  // Output stability while stalled.
  logic        stall_prev = 1'b0;
  logic [31:0] inst_prev;
  logic [1:0]  err_prev;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && stall_prev) begin
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_inst", {32'b0, out_inst}, {32'b0, inst_prev});
      check("stall_err", {62'b0, out_err}, {62'b0, err_prev});
    end
    stall_prev = (rst_n === 1'b1) && out_valid && !out_ready;
    inst_prev  = out_inst;
    err_prev   = out_err;
  end

  always @(posedge clk) begin
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stale;
    in_valid = 1'b0; in_imm_type = '0; in_imm = '0; in_base = '0;
    out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_inst", {32'b0, out_inst}, 64'd0);
    check("rst_out_err", {62'b0, out_err}, 64'd0);
    check("rst_err_cnt", {48'b0, err_cnt}, 64'd0);
    check("rst_rt_fail", {63'b0, rt_fail}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First result appears two cycles after acceptance.
    send(3'd1, -64'sd1, 32'h0000_0013);
    @(negedge clk);
    check("latency_c1_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check("latency_c2_valid", {63'b0, out_valid}, 64'd1);
    drain();

    send(3'd2, 64'h7FF, 32'h0000_3023);
    send(3'd3, -64'sd4, 32'h0000_0063);
    send(3'd5, 64'd2048, 32'h0000_006F);
    send(3'd4, 64'h1234_5000, 32'h0000_0037);
    drain();
    check("err_cnt_clean", {48'b0, err_cnt}, 64'd0);

    send(3'd1, 64'd2048, 32'h0000_0013);
    send(3'd3, 64'd3, 32'h0000_0063);
    send(3'd7, 64'd5, 32'hDEAD_BEEF);
    drain();
    check("err_cnt_three", {48'b0, err_cnt}, 64'd3);

    // Backpressure: four requests against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(3'd1, 64'(i * 37 + 1), 32'h0000_0013 | (32'(i) << 7));
      end
    join_none
    repeat (5) @(negedge clk);
    check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Randomized traffic with random backpressure.
    bp_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] t;
      t = 3'($urandom_range(0, 7));
      if (t == 3'd0 || t > 3'd5) t = 3'($urandom_range(0, 7));
      send(t, rand_imm(t), $urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_rand = 1'b0;
    out_ready = 1'b1;
    drain();
    check("err_cnt_random", {48'b0, err_cnt}, 64'(exp_err_cnt));
    check("rt_fail_random", {63'b0, rt_fail}, 64'd0);

    // Asynchronous reset with both stages holding data.
    out_ready = 1'b0;
    send(3'd1, 64'd4000, 32'h0000_0013);
    send(3'd2, 64'd12, 32'h0000_2023);
    check("pre_rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("async_rst_err_cnt", {48'b0, err_cnt}, 64'd0);
    check("async_rst_out_inst", {32'b0, out_inst}, 64'd0);
    sbq.delete();
    exp_err_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_after_reset", {63'b0, stale}, 64'd0);
    @(posedge clk);
    #1;
    send(3'd5, -64'sd2, 32'h0000_00EF);
    send(3'd4, 64'd1, 32'h0000_0017);
    drain();
    check("err_cnt_after_reset", {48'b0, err_cnt}, 64'(exp_err_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
